// File: rtl/rom128xn_streamer_if.sv
// rtl/rom128xn_streamer_if.sv - stream bundle between the ROM streamer and its consumer
interface rom128xn_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rom128xn_streamer.sv
// rtl/rom128xn_streamer.sv - streams a contiguous run of 128-deep ROM words with backpressure
module rom128xn_streamer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [6:0]            start_addr,
    input  logic [7:0]            length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_cen,
    output logic [6:0]            rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    rom128xn_streamer_if.master   m
);

    localparam int DEPTH = ROM_LATENCY + 2;

    if (ROM_LATENCY != 0 && ROM_LATENCY != 1) begin : g_bad_latency
        $error("rom128xn_streamer: ROM_LATENCY must be 0 or 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [6:0]            addr_q;
    logic [7:0]            issue_left_q;
    logic [7:0]            beat_left_q;
    logic [DATA_WIDTH-1:0] mem [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q, count_q;
    logic                  inflight_q;
    logic                  done_q;

    logic       accept, issue, capture, pop, final_pop;
    logic [7:0] run_len;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign run_len   = (length > 8'd128) ? 8'd128 : length;
    assign accept    = (state_q == IDLE) && start && (length != 8'd0) && !done_q && !abort;
    // Occupancy plus the read still inside the ROM must leave room, so no capture can overflow.
    assign issue     = (state_q == RUN) && !abort &&
                       (({1'b0, count_q} + {2'b00, inflight_q}) < 3'(DEPTH));
    assign capture   = (ROM_LATENCY == 1) ? inflight_q : issue;
    assign pop       = m.tvalid && m.tready;
    assign final_pop = pop && (beat_left_q == 8'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (issue && issue_left_q == 8'd1) state_d = DRAIN;
            DRAIN:   if (final_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= 7'd0;
            issue_left_q <= 8'd0;
            beat_left_q  <= 8'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= final_pop && !abort && (state_q == DRAIN);
            if (abort) begin
                issue_left_q <= 8'd0;
                beat_left_q  <= 8'd0;
                wr_ptr_q     <= 2'd0;
                rd_ptr_q     <= 2'd0;
                count_q      <= 2'd0;
                inflight_q   <= 1'b0;
            end else begin
                if (accept) begin
                    addr_q       <= start_addr;
                    issue_left_q <= run_len;
                    beat_left_q  <= run_len;
                end
                if (issue) begin
                    addr_q       <= addr_q + 7'd1;
                    issue_left_q <= issue_left_q - 8'd1;
                end
                inflight_q <= issue && (ROM_LATENCY == 1);
                if (capture) begin
                    mem[wr_ptr_q] <= rom_dout;
                    wr_ptr_q      <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q    <= ptr_inc(rd_ptr_q);
                    beat_left_q <= beat_left_q - 8'd1;
                end
                case ({capture, pop})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (rstn && capture && !pop && !abort)
            assert (count_q != 2'(DEPTH)) else $error("rom128xn_streamer: output fifo overflow");
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_cen  = issue;
    assign rom_addr = addr_q;
    assign m.tvalid = (count_q != 2'd0);
    assign m.tlast  = m.tvalid && (beat_left_q == 8'd1);
    assign m.tdata  = m.tvalid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_rom128xn_streamer.sv
// tb/tb_rom128xn_streamer.sv - randomized bench for both ROM latencies against a run-level model
module tb_rom128xn_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, abort;
    logic [6:0]  start_addr;
    logic [7:0]  length;
    logic        tready = 1'b0;
    int          ready_mode;

    logic [1:0]  busy_v, done_v, cen_v, tv, tl;
    logic [6:0]  ra [2];
    logic [31:0] td [2];
    logic [31:0] rd0, rd1;
    logic [31:0] rom [128];

    rom128xn_streamer_if #(.DATA_WIDTH(32)) s0 ();
    rom128xn_streamer_if #(.DATA_WIDTH(32)) s1 ();

    rom128xn_streamer #(.DATA_WIDTH(32), .ROM_LATENCY(1)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .length(length),
        .abort(abort), .busy(busy_v[0]), .done(done_v[0]), .rom_cen(cen_v[0]),
        .rom_addr(ra[0]), .rom_dout(rd0), .m(s0.master));

    rom128xn_streamer #(.DATA_WIDTH(32), .ROM_LATENCY(0)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .length(length),
        .abort(abort), .busy(busy_v[1]), .done(done_v[1]), .rom_cen(cen_v[1]),
        .rom_addr(ra[1]), .rom_dout(rd1), .m(s1.master));

    assign s0.tready = tready;
    assign s1.tready = tready;
    assign tv = {s1.tvalid, s0.tvalid};
    assign tl = {s1.tlast, s0.tlast};
    assign td[0] = s0.tdata;
    assign td[1] = s1.tdata;

    always @(posedge clk) if (cen_v[0]) rd0 <= rom[ra[0]];
    assign rd1 = rom[ra[1]];

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = ($urandom_range(0, 9) < 3);
            default: tready = 1'b0;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Run-level model: beat k of a run carries rom[(addr + k) mod 128], last on k == len-1.
    int         run_id = 0;
    logic [6:0] cmd_addr;
    int         cmd_len;
    int         k [2], dones [2], seen [2];
    logic       stall_prev [2];
    logic [31:0] prev_d [2];
    logic       prev_l [2];

    initial for (int i = 0; i < 2; i++) begin
        k[i] = 0; dones[i] = 0; seen[i] = 0; stall_prev[i] = 1'b0; prev_d[i] = 0; prev_l[i] = 1'b0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (seen[i] != run_id) begin
                seen[i] = run_id;
                k[i] = 0;
            end
            if (!rstn) begin
                stall_prev[i] = 1'b0;
            end else begin
                if (stall_prev[i]) begin
                    check_eq($sformatf("hold_valid%0d", i), tv[i], 1);
                    check_eq($sformatf("hold_data%0d", i), td[i], prev_d[i]);
                    check_eq($sformatf("hold_last%0d", i), tl[i], prev_l[i]);
                end
                if (tv[i] && tready) begin
                    if (k[i] >= cmd_len)
                        check_eq($sformatf("extra_beat%0d", i), k[i], cmd_len);
                    else begin
                        check_eq($sformatf("beat_data%0d", i), td[i], rom[cmd_addr + 7'(k[i])]);
                        check_eq($sformatf("beat_last%0d", i), tl[i], k[i] == cmd_len - 1);
                    end
                    k[i]++;
                end
                if (done_v[i]) dones[i]++;
                stall_prev[i] = tv[i] && !tready && !abort;
                prev_d[i] = td[i];
                prev_l[i] = tl[i];
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, busy_v, 0);
        check_eq({tag, "_done"}, done_v, 0);
        check_eq({tag, "_cen"}, cen_v, 0);
        check_eq({tag, "_tvalid"}, tv, 0);
        check_eq({tag, "_tlast"}, tl, 0);
        check_eq({tag, "_tdata0"}, td[0], 0);
        check_eq({tag, "_tdata1"}, td[1], 0);
        check_eq({tag, "_addr0"}, ra[0], 0);
        check_eq({tag, "_addr1"}, ra[1], 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_v != 0 || done_v != 0) && n < budget);
        if (n >= budget) check_eq("timeout_busy", busy_v, 0);
    endtask

    task automatic issue_start(input logic [6:0] a, input logic [7:0] len);
        cmd_addr = a;
        cmd_len  = (len > 8'd128) ? 128 : int'(len);
        run_id++;
        start_addr = a;
        length = len;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_cmd(input logic [6:0] a, input logic [7:0] len, input bit inject, input int budget);
        int d0, d1, exp_done;
        @(posedge clk);
        #1;
        d0 = dones[0];
        d1 = dones[1];
        exp_done = (len != 0) ? 1 : 0;
        issue_start(a, len);
        if (inject) begin
            repeat (5) @(posedge clk);
            #1 start_addr = ~a; length = 8'd7; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_idle(budget);
        check_eq("beats0", k[0], cmd_len);
        check_eq("beats1", k[1], cmd_len);
        check_eq("done_count0", dones[0] - d0, exp_done);
        check_eq("done_count1", dones[1] - d1, exp_done);
    endtask

    initial begin
        int d0, d1;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; start_addr = 7'd0; length = 8'd0;
        ready_mode = 0;
        for (int n = 0; n < 128; n++) rom[n] = 32'h100 + n;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;

        // Basic cycle-accurate run: start sampled at cycle 0.
        @(posedge clk);
        #1;
        issue_start(7'h10, 8'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("basic_busy0_c%0d", c), busy_v[0], c <= 6);
            check_eq($sformatf("basic_busy1_c%0d", c), busy_v[1], c <= 5);
            check_eq($sformatf("basic_tvalid0_c%0d", c), tv[0], c >= 3 && c <= 6);
            check_eq($sformatf("basic_tvalid1_c%0d", c), tv[1], c >= 2 && c <= 5);
            check_eq($sformatf("basic_done0_c%0d", c), done_v[0], c == 7);
            check_eq($sformatf("basic_done1_c%0d", c), done_v[1], c == 6);
            check_eq($sformatf("basic_cen0_c%0d", c), cen_v[0], c <= 4);
            check_eq($sformatf("basic_cen1_c%0d", c), cen_v[1], c <= 4);
            if (c <= 4) check_eq($sformatf("basic_addr0_c%0d", c), ra[0], 7'h10 + 7'(c - 1));
            if (c >= 3 && c <= 6) begin
                check_eq($sformatf("basic_data0_c%0d", c), td[0], 32'h110 + 32'(c - 3));
                check_eq($sformatf("basic_last0_c%0d", c), tl[0], c == 6);
            end
        end
        check_eq("basic_beats0", k[0], 4);
        check_eq("basic_beats1", k[1], 4);

        run_cmd(7'h7E, 8'd4, 1'b0, 100);
        run_cmd(7'($urandom), 8'd200, 1'b0, 400);
        run_cmd(7'h33, 8'd0, 1'b0, 20);
        check_eq("len0_busy", busy_v, 0);

        ready_mode = 1;
        run_cmd(7'($urandom), 8'd128, 1'b0, 3000);
        run_cmd(7'($urandom), 8'd40, 1'b1, 1500);

        // Abort with the fifo full and the sink stalled.
        ready_mode = 2;
        @(posedge clk);
        #1;
        d0 = dones[0];
        d1 = dones[1];
        issue_start(7'h20, 8'd20);
        repeat (8) @(negedge clk);
        check_eq("full_cen", cen_v, 0);
        check_eq("full_tvalid", tv, 2'b11);
        check_eq("full_busy", busy_v, 2'b11);
        @(posedge clk);
        #1 abort = 1'b1; start = 1'b1; length = 8'd5;
        @(posedge clk);
        #1 abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("abort_tvalid", tv, 0);
        check_eq("abort_busy", busy_v, 0);
        repeat (3) @(negedge clk);
        check_eq("abort_still_idle", busy_v, 0);
        check_eq("abort_no_done0", dones[0] - d0, 0);
        check_eq("abort_no_done1", dones[1] - d1, 0);
        ready_mode = 0;
        run_cmd(7'($urandom), 8'd2, 1'b0, 100);

        // Asynchronous reset in the middle of a run.
        ready_mode = 1;
        @(posedge clk);
        #1;
        issue_start(7'($urandom), 8'd50);
        repeat (10) @(posedge clk);
        #3 rstn = 1'b0;
        #1 check_outputs_zero("midrun_reset");
        @(negedge clk) rstn = 1'b1;

        for (int n = 0; n < 128; n++) rom[n] = $urandom;
        for (int r = 0; r < 6; r++) begin
            ready_mode = int'($urandom_range(0, 1));
            run_cmd(7'($urandom), 8'($urandom_range(0, 255)), 1'b0, 3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom128xn_streamer.md
# rom128xN_streamer

Reads a contiguous run of entries from a 128-deep registered ROM (`rom128xN`, `OUTPUT_REG = "TRUE"`) and emits them as an AXI4-Stream master with full backpressure support. It drives the ROM address/enable pins, tracks in-flight reads against a small output FIFO, and delivers one word per cycle when the sink is ready. It sits between a control FSM, which issues start/length commands, and any stream consumer of ROM-held tables: init sequences, calibration words, register scripts.

## Interface

- `DATA_WIDTH`, 32: ROM word and stream width.
- `ROM_LATENCY`, 1: ROM read latency in cycles.
  - 1: registered ROM.
  - 0: combinational ROM.
  - Other values are rejected at elaboration with `$error`.
- `clk` input 1: single clock; all logic rising-edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `start_addr` input 7: first ROM address of the run.
- `length` input 8: number of words to emit.
  - 0: command ignored.
  - 129..255: saturated to 128.
- `abort` input 1: synchronous flush back to IDLE.
- `busy` output 1: a run is in progress.
- `done` output 1: one-cycle pulse after the final beat is accepted.
- `rom_cen` output 1: ROM read enable, tied to the ROM `cen` port.
- `rom_addr` output 7: ROM address.
- `rom_dout` input DATA_WIDTH: ROM data.
- `m_tdata` output DATA_WIDTH: stream data.
- `m_tvalid` output 1: stream valid.
- `m_tready` input 1: stream ready.
- `m_tlast` output 1: marks the final beat of the run.

## Operation

- **States**
  - IDLE -> RUN on `start` with length != 0; latches address and count.
  - RUN -> DRAIN when the last read has been issued.
  - DRAIN -> IDLE when the FIFO is empty and no read is in flight; asserts `done` for one cycle on this transition.
- **Output FIFO**
  - Depth = ROM_LATENCY + 2.
  - A read is issued, with `rom_cen` = 1 and `rom_addr` = current address, only when FIFO occupancy + reads in flight < depth.
  - This sizing guarantees no overflow under any `m_tready` pattern and sustains 1 word/cycle when `m_tready` is held high.
- **Capture**
  - ROM_LATENCY=1: `rom_dout` is written into the FIFO the cycle after the issue.
  - ROM_LATENCY=0: written in the same cycle as the issue.
  - With `rom_cen` low, the registered ROM holds its output; that held value is never captured.
- **Address** increments by 1 per issue and wraps from 0x7F to 0x00 (modulo 128).
- **Handshake**
  - Transfer when `m_tvalid` && `m_tready`.
  - `m_tdata`/`m_tvalid`/`m_tlast` stay stable while `m_tvalid` && !`m_tready`.
  - `m_tvalid` never depends combinationally on `m_tready`.
- **`m_tlast`** is high only on the beat carrying the last word of the run.
- **`busy`** is high from the cycle after an accepted `start` through the final-beat transfer cycle. It is low in the `done` cycle.
- **`start` gating**: `start` while `busy` or during the `done` cycle is ignored.
- **`abort`**
  - In any state: FIFO cleared, in-flight reads discarded, next state IDLE.
  - No `done`, no `m_tlast`. `m_tvalid` is 0 from the next cycle.
  - `abort` and `start` in the same cycle: `abort` wins and `start` is ignored.
- **Reset**: all outputs 0, counters 0, state IDLE. Reset mid-run discards everything immediately, asynchronously.

## Timing

- ROM_LATENCY=1:
  - `start` sampled at cycle 0.
  - Cycle 1: `rom_cen`=1 with `rom_addr`=`start_addr`.
  - Cycle 2: capture into FIFO.
  - Cycle 3: `m_tvalid`=1.
- ROM_LATENCY=0: first `m_tvalid` at cycle 2.
- With `m_tready` held high, N words occupy N consecutive beat cycles. `done` follows the last beat by exactly 1 cycle.
- With the FIFO at depth, `rom_cen` drops within the same cycle the issue condition fails. Issuing resumes the cycle after a pop frees a slot.
- Minimum spacing between the `done` pulse and the next accepted `start` is 1 cycle (`start` accepted in the cycle after `done`).

## Test plan

- **Basic run.** ROM[n]=n+0x100, `start_addr`=0x10, `length`=4, `m_tready`=1 -> beats 0x110..0x113 on cycles 3..6, `m_tlast` on 0x113, `done` at cycle 7, `busy` cycles 1..6.
- **Wrap-around.** `start_addr`=0x7E, `length`=4 -> addresses 0x7E, 0x7F, 0x00, 0x01 in order.
- **Saturation.** `length`=200 -> exactly 128 beats, wrapping to the start address, `m_tlast` on beat 128.
- **Backpressure.** `m_tready` random 30% high, `length`=128, ROM_LATENCY 0 and 1 -> in-order lossless data, no duplicates, `m_tdata` stable while stalled, FIFO never overflows (assertion).
- **Abort.** `abort` mid-RUN with the FIFO full -> `m_tvalid` 0 next cycle, no `done`. A following `start` with `length`=2 yields exactly 2 fresh beats.
- **Reset and ignored commands.** `rstn` low mid-run -> all outputs 0 asynchronously. `length`=0 and `start` while `busy` -> no state change.
